// File: rtl/wash_cycle_sequencer_pkg.sv
// Shared wash-program definitions: state codes, actuator bundle and its per-state decode.
// Used by the sequencer, the panel and the testbench.
package wash_cycle_sequencer_pkg;

  localparam int unsigned PHASE_W = 4;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_FILL   = 4'd1,
    ST_WASH   = 4'd2,
    ST_DRAIN  = 4'd3,
    ST_RFILL  = 4'd4,
    ST_RINSE  = 4'd5,
    ST_RDRAIN = 4'd6,
    ST_SPIN   = 4'd7,
    ST_DONE   = 4'd8,
    ST_PAUSE  = 4'd9
  } state_e;

  typedef struct packed {
    logic water;
    logic agitator;
    logic motor;
    logic pump;
    logic speed;
  } act_t;

  function automatic act_t act_decode(state_e s);
    act_t a;
    a = '0;
    case (s)
      ST_FILL, ST_RFILL:   a.water = 1'b1;
      ST_WASH, ST_RINSE: begin
        a.agitator = 1'b1;
        a.motor    = 1'b1;
      end
      ST_DRAIN, ST_RDRAIN: a.pump = 1'b1;
      ST_SPIN: begin
        a.pump  = 1'b1;
        a.motor = 1'b1;
        a.speed = 1'b1;
      end
      default:             a = '0;
    endcase
    return a;
  endfunction

  // Phases an abort request may cut short; later phases already end in a drain.
  function automatic logic is_abortable(state_e s);
    return (s == ST_FILL) || (s == ST_WASH) || (s == ST_DRAIN) ||
           (s == ST_RFILL) || (s == ST_RINSE);
  endfunction

  function automatic logic is_busy(state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/wash_cycle_sequencer_if.sv
// Front-panel inputs and actuator outputs of the wash sequencer.
interface wash_cycle_sequencer_if;
  import wash_cycle_sequencer_pkg::*;

  logic               door;
  logic               start;
  logic [1:0]         load;
  logic               abort;
  logic               water;
  logic               agitator;
  logic               motor;
  logic               pump;
  logic               speed;
  logic               busy;
  logic               done;
  logic [PHASE_W-1:0] phase;

  modport master (
    output door, start, load, abort,
    input  water, agitator, motor, pump, speed, busy, done, phase
  );

  modport slave (
    input  door, start, load, abort,
    output water, agitator, motor, pump, speed, busy, done, phase
  );
endinterface

// File: rtl/wash_cycle_sequencer_phase_timer.sv
// Phase down-counter: loaded on phase entry, decremented per active cycle.
module wash_cycle_sequencer_phase_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [TW-1:0] load_val,
  input  logic          dec_en,
  output logic          last
);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load_en) begin
      r_count <= load_val;
    end else if (dec_en && (r_count != '0)) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign last = (r_count == TW'(1));

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Wash-program sequencer: phase FSM with door pause, abort-to-drain and load-scaled durations.
module wash_cycle_sequencer
  import wash_cycle_sequencer_pkg::*;
#(
  parameter int unsigned FILL_CYC  = 2,
  parameter int unsigned WASH_CYC  = 4,
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned SPIN_CYC  = 2,
  parameter int unsigned TW        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  wash_cycle_sequencer_if.slave bus
);

  localparam int unsigned TMAX = (32'd1 << TW) - 32'd1;

  // Largest load (3) must fit every scaled duration in the timer.
  if ((TW == 0) || (FILL_CYC == 0) || (WASH_CYC == 0) || (DRAIN_CYC == 0) || (SPIN_CYC == 0) ||
      (FILL_CYC * 3 > TMAX) || (WASH_CYC * 3 > TMAX) ||
      (DRAIN_CYC > TMAX) || (SPIN_CYC * 3 > TMAX)) begin : g_tw_check
    $error("wash_cycle_sequencer: phase durations must be nonzero and fit in TW bits");
  end

  state_e             r_state;
  state_e             w_next;
  state_e             r_resume;
  state_e             w_resume_d;
  state_e             w_succ;
  logic               r_abort_pend;
  logic               w_abort_pend_d;
  logic               r_skip_spin;
  logic               w_skip_spin_d;
  logic [1:0]         r_load_q;
  logic [1:0]         w_load_q_d;
  logic               w_tload;
  logic               w_tdec;
  logic [TW-1:0]      w_tval;
  logic [TW-1:0]      w_succ_dur;
  logic               w_last;
  act_t               r_act;
  logic               r_busy;
  logic               r_done;
  logic [PHASE_W-1:0] r_phase;

  function automatic logic [TW-1:0] dur_of(state_e s, logic [1:0] ld);
    logic [TW-1:0] d;
    d = '0;
    case (s)
      ST_FILL, ST_RFILL:   d = TW'(FILL_CYC * 32'(ld));
      ST_WASH:             d = TW'(WASH_CYC * 32'(ld));
      ST_RINSE:            d = TW'(WASH_CYC);
      ST_DRAIN, ST_RDRAIN: d = TW'(DRAIN_CYC);
      ST_SPIN:             d = TW'(SPIN_CYC * 32'(ld));
      default:             d = '0;
    endcase
    return d;
  endfunction

  wash_cycle_sequencer_phase_timer #(
    .TW(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_en  (w_tload),
    .load_val (w_tval),
    .dec_en   (w_tdec),
    .last     (w_last)
  );

  // Normal successor of each active phase; an aborted program skips SPIN.
  always_comb begin
    w_succ = ST_IDLE;
    case (r_state)
      ST_FILL:   w_succ = ST_WASH;
      ST_WASH:   w_succ = ST_DRAIN;
      ST_DRAIN:  w_succ = ST_RFILL;
      ST_RFILL:  w_succ = ST_RINSE;
      ST_RINSE:  w_succ = ST_RDRAIN;
      ST_RDRAIN: w_succ = r_skip_spin ? ST_DONE : ST_SPIN;
      ST_SPIN:   w_succ = ST_DONE;
      default:   w_succ = ST_IDLE;
    endcase
  end

  assign w_succ_dur = dur_of(w_succ, r_load_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_resume     <= ST_IDLE;
      r_abort_pend <= 1'b0;
      r_skip_spin  <= 1'b0;
      r_load_q     <= 2'd0;
    end else begin
      r_state      <= w_next;
      r_resume     <= w_resume_d;
      r_abort_pend <= w_abort_pend_d;
      r_skip_spin  <= w_skip_spin_d;
      r_load_q     <= w_load_q_d;
    end
  end

  // Next state, timer control and held-phase bookkeeping; door > abort > expiry.
  always_comb begin
    w_next         = r_state;
    w_resume_d     = r_resume;
    w_abort_pend_d = r_abort_pend;
    w_skip_spin_d  = r_skip_spin;
    w_load_q_d     = r_load_q;
    w_tload        = 1'b0;
    w_tdec         = 1'b0;
    w_tval         = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.door && (bus.load != 2'd0)) begin
          w_next        = ST_FILL;
          w_load_q_d    = bus.load;
          w_skip_spin_d = 1'b0;
          w_tload       = 1'b1;
          w_tval        = dur_of(ST_FILL, bus.load);
        end
      end
      ST_DONE: begin
        w_next        = ST_IDLE;
        w_skip_spin_d = 1'b0;
      end
      ST_PAUSE: begin
        if (!bus.door) begin
          w_abort_pend_d = 1'b0;
          if ((r_abort_pend || bus.abort) && (r_resume != ST_DONE)) begin
            w_next        = ST_RDRAIN;
            w_skip_spin_d = 1'b1;
            w_tload       = 1'b1;
            w_tval        = dur_of(ST_RDRAIN, r_load_q);
          end else begin
            w_next = r_resume;
          end
        end else if (bus.abort) begin
          w_abort_pend_d = 1'b1;
        end
      end
      ST_FILL, ST_WASH, ST_DRAIN, ST_RFILL, ST_RINSE, ST_RDRAIN, ST_SPIN: begin
        if (bus.door) begin
          // The cycle that saw the door was still active, so it is counted.
          w_next = ST_PAUSE;
          if (w_last) begin
            w_resume_d = w_succ;
            w_tload    = 1'b1;
            w_tval     = w_succ_dur;
          end else begin
            w_resume_d = r_state;
            w_tdec     = 1'b1;
          end
        end else if (bus.abort && is_abortable(r_state)) begin
          w_next        = ST_RDRAIN;
          w_skip_spin_d = 1'b1;
          w_tload       = 1'b1;
          w_tval        = dur_of(ST_RDRAIN, r_load_q);
        end else if (w_last) begin
          w_next  = w_succ;
          w_tload = 1'b1;
          w_tval  = w_succ_dur;
        end else begin
          w_tdec = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs registered from the next state so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_phase <= '0;
    end else begin
      r_act   <= act_decode(w_next);
      r_busy  <= is_busy(w_next);
      r_done  <= (w_next == ST_DONE);
      r_phase <= w_next;
    end
  end

  assign bus.water    = r_act.water;
  assign bus.agitator = r_act.agitator;
  assign bus.motor    = r_act.motor;
  assign bus.pump     = r_act.pump;
  assign bus.speed    = r_act.speed;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.phase    = r_phase;

endmodule
